// File: rtl/stall_control_unit_pkg.sv
// Shared types for the pipeline stall controller: FSM encoding,
// control-word layout and the NOP instruction constant.
package stall_control_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_wr_ena;
    logic if_id_wr_ena;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = ctrl_t'(5'b11000);
  localparam ctrl_t CTRL_FRZ = ctrl_t'(5'b00001);
  localparam ctrl_t CTRL_LU  = ctrl_t'(5'b00010);
  localparam ctrl_t CTRL_BR  = ctrl_t'(5'b11110);
  localparam ctrl_t CTRL_FL  = ctrl_t'(5'b11100);
  localparam ctrl_t CTRL_RST = ctrl_t'(5'b00110);

endpackage

// File: rtl/stall_control_unit_if.sv
// Hazard inputs from ID/EX/MEM and pipeline control outputs.
interface stall_control_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [REG_ADDR_WIDTH-1:0] id_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rt_addr;
  logic                      id_uses_rt;
  logic [REG_ADDR_WIDTH-1:0] ex_reg_addr;
  logic                      ex_reg_wr_ena;
  logic                      ex_mem_rd;
  logic                      branch_taken;
  logic                      mem_req;
  logic                      dmem_ready;
  logic                      pc_wr_ena;
  logic                      if_id_wr_ena;
  logic                      if_id_flush;
  logic                      id_ex_bubble;
  logic                      pipe_hold;
  logic [CNT_WIDTH-1:0]      stall_cycles;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rt,
    output ex_reg_addr, ex_reg_wr_ena, ex_mem_rd,
    output branch_taken, mem_req, dmem_ready,
    input  pc_wr_ena, if_id_wr_ena, if_id_flush,
    input  id_ex_bubble, pipe_hold, stall_cycles
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rt,
    input  ex_reg_addr, ex_reg_wr_ena, ex_mem_rd,
    input  branch_taken, mem_req, dmem_ready,
    output pc_wr_ena, if_id_wr_ena, if_id_flush,
    output id_ex_bubble, pipe_hold, stall_cycles
  );
endinterface

// File: rtl/stall_control_unit_load_use_detect.sv
// Load-use hazard comparator: EX load feeding a source of the ID
// instruction; register 0 never hazards.
module load_use_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic                      id_uses_rt,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_addr,
  input  logic                      ex_reg_wr_ena,
  input  logic                      ex_mem_rd,
  output logic                      load_use
);
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = ex_reg_addr == id_rs_addr;
  assign rt_hit = id_uses_rt & (ex_reg_addr == id_rt_addr);

  assign load_use = ex_mem_rd & ex_reg_wr_ena &
                    (ex_reg_addr != '0) & (rs_hit | rt_hit);
endmodule

// File: rtl/stall_control_unit.sv
// Pipeline stall/flush controller. Define STALL_COUNTER_EN to
// build the saturating stall-cycle counter; otherwise it reads 0.
module stall_control_unit
  import stall_control_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 1,
  parameter int CNT_WIDTH      = 16
) (
  input logic                clk,
  input logic                rst,
  stall_control_unit_if.slave bus
);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] fcnt;
  logic [1:0] fcnt_nxt;
  logic       load_use;
  logic       mem_stall;
  ctrl_t      ctrl;

  load_use_detect #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .id_rs_addr   (bus.id_rs_addr),
    .id_rt_addr   (bus.id_rt_addr),
    .id_uses_rt   (bus.id_uses_rt),
    .ex_reg_addr  (bus.ex_reg_addr),
    .ex_reg_wr_ena(bus.ex_reg_wr_ena),
    .ex_mem_rd    (bus.ex_mem_rd),
    .load_use     (load_use)
  );

  assign mem_stall = bus.mem_req & ~bus.dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
        end else if (bus.branch_taken && FLUSH_CYCLES > 1) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FLUSH_LOAD;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) state_nxt = RUN;
      end
      FLUSH: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          fcnt_nxt  = '0;
        end else if (bus.branch_taken) begin
          fcnt_nxt = FLUSH_LOAD;
        end else begin
          fcnt_nxt = fcnt - 2'd1;
          if (fcnt == 2'd1) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        fcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    ctrl = CTRL_RUN;
    if (rst) begin
      ctrl = CTRL_RST;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall)             ctrl = CTRL_FRZ;
          else if (bus.branch_taken) ctrl = CTRL_BR;
          else if (load_use)         ctrl = CTRL_LU;
        end
        MEM_WAIT: begin
          if (!bus.dmem_ready) ctrl = CTRL_FRZ;
        end
        FLUSH: begin
          // ID already holds a flushed NOP, so load-use is moot here
          if (mem_stall)             ctrl = CTRL_FRZ;
          else if (bus.branch_taken) ctrl = CTRL_BR;
          else                       ctrl = CTRL_FL;
        end
        default: ctrl = CTRL_RUN;
      endcase
    end
  end

  assign bus.pc_wr_ena    = ctrl.pc_wr_ena;
  assign bus.if_id_wr_ena = ctrl.if_id_wr_ena;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_bubble = ctrl.id_ex_bubble;
  assign bus.pipe_hold    = ctrl.pipe_hold;

`ifdef STALL_COUNTER_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!ctrl.pc_wr_ena && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_stall_control_unit.sv
// Vector table plus multi-cycle sequences against a queue
// scoreboard for stall_control_unit built with FLUSH_CYCLES=2.
module tb_stall_control_unit;
  logic clk;
  logic rst;

  stall_control_unit_if #(
    .REG_ADDR_WIDTH(5),
    .CNT_WIDTH     (16)
  ) bus ();

  stall_control_unit #(
    .REG_ADDR_WIDTH(5),
    .FLUSH_CYCLES  (2),
    .CNT_WIDTH     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] ex_addr;
    logic       wr;
    logic       mrd;
    logic       br;
    logic       mreq;
    logic       rdy;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] E_RUN = 5'b11000;
  localparam logic [4:0] E_FRZ = 5'b00001;
  localparam logic [4:0] E_LU  = 5'b00010;
  localparam logic [4:0] E_BR  = 5'b11110;
  localparam logic [4:0] E_FL  = 5'b11100;
  localparam logic [4:0] E_RST = 5'b00110;

  logic [4:0]  exp_q[$];
  logic [15:0] cnt_q[$];
  logic [15:0] exp_cnt;
  int          n_chk;
  int          n_fail;
  vec_t        tbl[10];

  function automatic vec_t mk(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic u, input logic [4:0] ex,
    input logic wr, input logic mrd, input logic br,
    input logic mreq, input logic rdy,
    input logic [4:0] exp
  );
    vec_t v;
    v = '{rs, rt, u, ex, wr, mrd, br, mreq, rdy, exp};
    return v;
  endfunction

  function automatic vec_t idle(input logic [4:0] exp);
    return mk(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0,
              1'b0, 1'b0, 1'b0, exp);
  endfunction

  function automatic vec_t br(input logic [4:0] exp);
    return mk(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0,
              1'b1, 1'b0, 1'b0, exp);
  endfunction

  function automatic vec_t mem(
    input logic rdy, input logic b, input logic [4:0] exp
  );
    return mk(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0,
              b, 1'b1, rdy, exp);
  endfunction

  task automatic apply(input vec_t v, input logic r, input string nm);
    logic [4:0]  got;
    logic [4:0]  e;
    logic [15:0] ec;
    bus.id_rs_addr    = v.rs;
    bus.id_rt_addr    = v.rt;
    bus.id_uses_rt    = v.uses_rt;
    bus.ex_reg_addr   = v.ex_addr;
    bus.ex_reg_wr_ena = v.wr;
    bus.ex_mem_rd     = v.mrd;
    bus.branch_taken  = v.br;
    bus.mem_req       = v.mreq;
    bus.dmem_ready    = v.rdy;
    rst               = r;
    if (r) exp_cnt = '0;
    exp_q.push_back(v.exp);
`ifdef STALL_COUNTER_EN
    cnt_q.push_back(exp_cnt);
`else
    cnt_q.push_back(16'd0);
`endif
    @(negedge clk);
    e   = exp_q.pop_front();
    ec  = cnt_q.pop_front();
    got = {bus.pc_wr_ena, bus.if_id_wr_ena, bus.if_id_flush,
           bus.id_ex_bubble, bus.pipe_hold};
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s ctrl got=%b want=%b", nm, got, e);
    end
    n_chk++;
    if (bus.stall_cycles !== ec) begin
      n_fail++;
      $display("FAIL %s stall_cycles got=%0d want=%0d",
               nm, bus.stall_cycles, ec);
    end
    if (!r && !e[4] && exp_cnt != 16'hffff) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_cnt = '0;
    rst     = 1'b1;

    tbl[0] = idle(E_RUN);
    tbl[1] = mk(5, 2, 0, 5, 1, 1, 0, 0, 0, E_LU);
    tbl[2] = idle(E_RUN);
    tbl[3] = mk(0, 0, 1, 0, 1, 1, 0, 0, 0, E_RUN);
    tbl[4] = mk(1, 5, 0, 5, 1, 1, 0, 0, 0, E_RUN);
    tbl[5] = mk(1, 5, 1, 5, 1, 1, 0, 0, 0, E_LU);
    tbl[6] = mk(5, 2, 1, 5, 0, 1, 0, 0, 0, E_RUN);
    tbl[7] = mk(5, 2, 1, 5, 1, 0, 0, 0, 0, E_RUN);
    tbl[8] = mk(5, 2, 1, 5, 1, 1, 0, 1, 1, E_LU);
    tbl[9] = idle(E_RUN);

    repeat (2) @(posedge clk);
    #1;
    apply(idle(E_RST), 1'b1, "reset");
    apply(idle(E_RUN), 1'b0, "post_reset");

    for (int i = 0; i < 10; i++)
      apply(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    for (int i = 0; i < 3; i++)
      apply(mem(1'b0, 1'b0, E_FRZ), 1'b0, "mem_wait");
    apply(mem(1'b1, 1'b0, E_RUN), 1'b0, "mem_done");
    apply(idle(E_RUN), 1'b0, "mem_after");

    apply(br(E_BR), 1'b0, "branch");
    apply(idle(E_FL), 1'b0, "flush2");
    apply(idle(E_RUN), 1'b0, "flush_end");

    apply(mk(5, 2, 0, 5, 1, 1, 1, 0, 0, E_BR), 1'b0, "br_lu");
    apply(mk(5, 2, 0, 5, 1, 1, 0, 0, 0, E_FL), 1'b0, "br_lu_fl");
    apply(idle(E_RUN), 1'b0, "br_lu_end");

    apply(br(E_BR), 1'b0, "reload0");
    apply(br(E_BR), 1'b0, "reload1");
    apply(idle(E_FL), 1'b0, "reload_fl");
    apply(idle(E_RUN), 1'b0, "reload_end");

    apply(mem(1'b0, 1'b1, E_FRZ), 1'b0, "mem_br0");
    apply(mem(1'b0, 1'b1, E_FRZ), 1'b0, "mem_br1");
    apply(mem(1'b1, 1'b1, E_RUN), 1'b0, "mem_br_done");
    apply(idle(E_RUN), 1'b0, "mem_br_end");

    apply(br(E_BR), 1'b0, "pre_br");
    apply(mem(1'b0, 1'b0, E_FRZ), 1'b0, "pre_frz0");
    apply(mem(1'b0, 1'b0, E_FRZ), 1'b0, "pre_frz1");
    apply(mem(1'b1, 1'b0, E_RUN), 1'b0, "pre_done");
    apply(idle(E_RUN), 1'b0, "pre_end");

    apply(mem(1'b0, 1'b0, E_FRZ), 1'b0, "rw_frz0");
    apply(mem(1'b0, 1'b0, E_FRZ), 1'b0, "rw_frz1");
    apply(mem(1'b0, 1'b0, E_RST), 1'b1, "rw_rst");
    apply(idle(E_RUN), 1'b0, "rw_run0");
    apply(idle(E_RUN), 1'b0, "rw_run1");

    apply(br(E_BR), 1'b0, "rf_br");
    apply(idle(E_RST), 1'b1, "rf_rst");
    apply(idle(E_RUN), 1'b0, "rf_run");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stall_control_unit.md
STALL_CONTROL_UNIT -- requirements
Module: stall_control_unit

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter FLUSH_CYCLES, default 1, range 1..3; IF/ID flush length after a taken branch.
REQ-003 Parameter CNT_WIDTH, default 16, stall counter width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 id_rs_addr  input  REG_ADDR_WIDTH  source A register of the instruction in ID.
REQ-007 id_rt_addr  input  REG_ADDR_WIDTH  source B register of the instruction in ID.
REQ-008 id_uses_rt  input  1  ID instruction reads id_rt_addr.
REQ-009 ex_reg_addr  input  REG_ADDR_WIDTH  destination register of the instruction in EX.
REQ-010 ex_reg_wr_ena  input  1  EX instruction writes the register file.
REQ-011 ex_mem_rd  input  1  EX instruction is a load.
REQ-012 branch_taken  input  1  EX resolved a taken branch/jump.
REQ-013 mem_req  input  1  MEM stage issues a data-memory access.
REQ-014 dmem_ready  input  1  data memory completes the access this cycle.
REQ-015 pc_wr_ena  output  1  PC update enable.
REQ-016 if_id_wr_ena  output  1  IF/ID register enable.
REQ-017 if_id_flush  output  1  IF/ID loads a NOP.
REQ-018 id_ex_bubble  output  1  ID/EX loads a NOP.
REQ-019 pipe_hold  output  1  EX/MEM and MEM/WB registers hold.
REQ-020 stall_cycles  output  CNT_WIDTH  stall cycle count (see Configuration).

Function
REQ-021 FSM states SHALL be RUN, MEM_WAIT, FLUSH; outputs combinational from state and inputs.
REQ-022 load_use = ex_mem_rd & ex_reg_wr_ena & (ex_reg_addr != 0) & ((ex_reg_addr == id_rs_addr) | (id_uses_rt & ex_reg_addr == id_rt_addr)).
REQ-023 RUN, no event: pc_wr_ena=1, if_id_wr_ena=1, if_id_flush=0, id_ex_bubble=0, pipe_hold=0.
REQ-024 Event priority SHALL be mem stall > branch flush > load-use.
REQ-025 RUN & mem_req & !dmem_ready: all enables 0, pipe_hold=1, bubble=0, flush=0 same cycle; next state MEM_WAIT.
REQ-026 MEM_WAIT: same freeze outputs; on dmem_ready outputs revert to RUN values that cycle and next state RUN; branch_taken and load_use ignored while in MEM_WAIT.
REQ-027 RUN & branch_taken (no mem stall): if_id_flush=1, id_ex_bubble=1, pc_wr_ena=1 same cycle; if FLUSH_CYCLES>1 go FLUSH with counter=FLUSH_CYCLES-1, else stay RUN.
REQ-028 FLUSH: if_id_flush=1, pc_wr_ena=1, counter decrements each cycle, RUN when it reaches 0; new branch_taken reloads counter; mem stall preempts to MEM_WAIT, discarding the counter.
REQ-029 RUN & load_use (no higher event): pc_wr_ena=0, if_id_wr_ena=0, id_ex_bubble=1 for exactly that cycle; state stays RUN.
REQ-030 Register 0 never triggers load_use.

Reset
REQ-031 While rst=1: state RUN, flush counter 0, stall_cycles 0, pc_wr_ena=0, if_id_wr_ena=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
REQ-032 Reset asserted mid-MEM_WAIT or FLUSH SHALL abort immediately; first cycle after deassertion behaves as RUN.

Configuration
REQ-033 Macro STALL_COUNTER_EN defined: stall_cycles increments (saturating at all-ones) each cycle pc_wr_ena=0 with rst=0.
REQ-034 Macro undefined: counter logic absent, stall_cycles tied to 0.

Structure
REQ-035 Shared package holds the FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2) and NOP encoding constant.
REQ-036 One sub-module: load_use_detect (combinational REQ-022 comparator).

Verification
REQ-037 ex_mem_rd=1, ex_reg_addr=5, wr_ena=1, id_rs_addr=5 -> one cycle pc_wr_ena=0, id_ex_bubble=1, then normal.
REQ-038 Same with ex_reg_addr=0, or match only on id_rt_addr with id_uses_rt=0 -> no stall.
REQ-039 mem_req=1, dmem_ready=0 for 3 cycles then 1 -> pipe_hold=1 for 3 cycles, RUN after; stall_cycles=3 with STALL_COUNTER_EN.
REQ-040 FLUSH_CYCLES=2, branch_taken one cycle -> if_id_flush=1 for 2 cycles, id_ex_bubble=1 first cycle only.
REQ-041 branch_taken and load_use same cycle -> flush behaviour only; mem stall with branch_taken -> freeze only.
REQ-042 rst pulsed during MEM_WAIT -> reset outputs immediately, RUN after release, stall_cycles=0.
